// File: rtl/lenet_pkg.sv
// lenet_pkg: shared state encoding and layer index constants for the LeNet accelerator
package lenet_pkg;
  localparam int N_LAYERS_DEF = 5;
  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC = 4;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_GAP, S_RUN, S_NEXT, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/lenet_watchdog.sv
// lenet_watchdog: saturating run-cycle counter that flags an engine hang
module lenet_watchdog #(
  parameter int TO_W = 20,
  parameter logic [TO_W-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  logic [TO_W:0] cnt_inc;
  assign cnt_inc = {1'b0, cnt} + (TO_W+1)'(1);
  // expired looks at the count this cycle completes, so RUN lasts exactly LIMIT cycles
  assign expired = en && (cnt_inc >= {1'b0, LIMIT});
  // count RUN cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt_inc[TO_W-1:0];
  end
endmodule

// File: rtl/lenet_layer_sched.sv
// lenet_layer_sched: sequences the LeNet layer engines and hands them the shared fm BRAM
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int N_LAYERS = N_LAYERS_DEF,
  parameter int TO_W = 20,
  parameter logic [TO_W-1:0] TO_LIMIT = 20'hF_FFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic [N_LAYERS-1:0] layer_finish,
  output logic [N_LAYERS-1:0] layer_rst,
  output logic [N_LAYERS-1:0] layer_en,
  output logic [2:0] bram_sel,
  output logic [2:0] cur_layer,
  output logic busy,
  output logic done,
  output logic error
);
  state_t state, state_n;
  logic [2:0] k, k_n;
  logic expired;
  logic [N_LAYERS-1:0] onehot_n;
  assign onehot_n = N_LAYERS'(1) << k_n;
  lenet_watchdog #(.TO_W(TO_W), .LIMIT(TO_LIMIT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(state == S_CLR),
    .en(state == S_RUN),
    .expired(expired)
  );
  // state and layer index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k <= 3'(L_CONV1);
    end else begin
      state <= state_n;
      k <= k_n;
    end
  end
  // next state: abort beats finish and timeout, and also blocks a same-cycle start
  always_comb begin
    state_n = state;
    k_n = k;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start && !abort) begin
          state_n = S_CLR;
          k_n = 3'(L_CONV1);
        end else if (state == S_DONE) state_n = S_IDLE;
      end
      S_CLR: state_n = abort ? S_ERR : S_GAP;
      S_GAP: state_n = abort ? S_ERR : S_RUN;
      S_RUN: state_n = abort ? S_ERR : layer_finish[k] ? S_NEXT : expired ? S_ERR : S_RUN;
      S_NEXT: begin
        if (abort) state_n = S_ERR;
        else if (k == 3'(N_LAYERS-1)) state_n = S_DONE;
        else begin
          state_n = S_CLR;
          k_n = k + 3'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  // outputs decoded from the next state so every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_rst <= '0;
      layer_en <= '0;
      bram_sel <= '0;
      cur_layer <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      layer_rst <= (state_n == S_CLR) ? onehot_n : '0;
      layer_en <= (state_n == S_RUN) ? onehot_n : '0;
      bram_sel <= k_n;
      cur_layer <= k_n;
      busy <= state_n inside {S_CLR, S_GAP, S_RUN, S_NEXT};
      done <= state_n == S_DONE;
      error <= state_n == S_ERR;
    end
  end
endmodule

// File: tb/tb_lenet_layer_sched.sv
// tb_lenet_layer_sched: directed checks of the layer scheduler against a simple engine model
module tb_lenet_layer_sched;
  localparam int DLY = 10;
  logic clk = 1'b0;
  logic rst, start, abort, model_init;
  logic [4:0] layer_finish, layer_rst, layer_en, hang, stale;
  logic [2:0] bram_sel, cur_layer, sel_prev;
  logic busy, done, error;
  logic [7:0] mcnt [5];
  int total = 0;
  int bad = 0;
  int c = 0;
  always #5 clk = ~clk;
  lenet_layer_sched #(.N_LAYERS(5), .TO_W(20), .TO_LIMIT(20'd50)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .layer_finish(layer_finish),
    .layer_rst(layer_rst), .layer_en(layer_en), .bram_sel(bram_sel), .cur_layer(cur_layer),
    .busy(busy), .done(done), .error(error)
  );
  // engine model: sticky finish cleared by its layer_rst, raised DLY cycles after en rises
  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (model_init) begin
        layer_finish[k] <= stale[k];
        mcnt[k] <= '0;
      end else if (layer_rst[k]) begin
        layer_finish[k] <= 1'b0;
        mcnt[k] <= '0;
      end else if (layer_en[k]) begin
        mcnt[k] <= mcnt[k] + 8'd1;
        if (mcnt[k] == 8'(DLY-1) && !hang[k]) layer_finish[k] <= 1'b1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    if (|layer_en) begin
      chk("sel_stable", 32'(bram_sel), 32'(sel_prev));
      chk("en_onehot", 32'($onehot(layer_en)), 32'd1);
    end
    sel_prev = bram_sel;
    @(posedge clk);
    #1;
    c++;
  endtask
  task automatic go();
    c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic tick_to(input int n);
    while (c < n) tick();
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_en"}, 32'(layer_en), 32'd0);
    chk({tag, "_lrst"}, 32'(layer_rst), 32'd0);
    chk({tag, "_sel"}, 32'(bram_sel), 32'd0);
    chk({tag, "_cur"}, 32'(cur_layer), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
  endtask
  task automatic capture(input string tag);
    int rst_c [5];
    int en_c [5];
    int done_c = -1;
    int ndone = 0;
    logic [4:0] pe = '0;
    for (int k = 0; k < 5; k++) begin
      rst_c[k] = -1;
      en_c[k] = -1;
    end
    go();
    for (int i = 0; i < 120; i++) begin
      for (int k = 0; k < 5; k++) begin
        if (layer_rst[k] && rst_c[k] < 0) rst_c[k] = c;
        if (layer_en[k] && !pe[k] && en_c[k] < 0) en_c[k] = c;
      end
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      pe = layer_en;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_rst%0d_cycle", tag, k), 32'(rst_c[k]), 32'(1 + 14*k));
      chk($sformatf("%s_en%0d_rise", tag, k), 32'(en_c[k]), 32'(3 + 14*k));
    end
    chk({tag, "_latency"}, 32'(done_c + 1), 32'(5*(DLY+4)+2));
    chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_err"}, 32'(error), 32'd0);
  endtask
  initial begin
    rst = 1'b1; model_init = 1'b1; start = 1'b0; abort = 1'b0; hang = '0; stale = '0;
    repeat (3) tick();
    chk_idle_outs("reset");
    rst = 1'b0; model_init = 1'b0;
    tick();
    capture("nominal");
    rst = 1'b1; model_init = 1'b1; stale = 5'b01000;
    repeat (2) tick();
    rst = 1'b0; model_init = 1'b0;
    tick();
    capture("stale");
    hang = 5'b00100;
    go();
    tick_to(80);
    chk("to_en_last_run", 32'(layer_en), 32'b00100);
    chk("to_err_before", 32'(error), 32'd0);
    tick();
    chk("to_en_low", 32'(layer_en), 32'd0);
    chk("to_err_set", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_cur", 32'(cur_layer), 32'd2);
    repeat (5) tick();
    chk("to_err_hold", 32'(error), 32'd1);
    chk("to_en_hold", 32'(layer_en), 32'd0);
    hang = '0;
    go();
    chk("restart_err_clr", 32'(error), 32'd0);
    chk("restart_lrst", 32'(layer_rst), 32'b00001);
    chk("restart_sel", 32'(bram_sel), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    tick_to(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_lrst", 32'(layer_rst), 32'd0);
    chk("busy_start_en", 32'(layer_en), 32'b00001);
    tick_to(20);
    chk("abort_pre_en", 32'(layer_en), 32'b00010);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_en", 32'(layer_en), 32'd0);
    chk("abort_err", 32'(error), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", 32'(bram_sel), 32'd1);
    chk("abort_lrst", 32'(layer_rst), 32'd0);
    tick();
    chk("abort_no_restart_lrst", 32'(layer_rst), 32'd0);
    chk("abort_no_restart_err", 32'(error), 32'd1);
    go();
    chk("midrst_start_err", 32'(error), 32'd0);
    tick_to(35);
    chk("midrst_pre_en", 32'(layer_en), 32'b00100);
    chk("midrst_pre_sel", 32'(bram_sel), 32'd2);
    rst = 1'b1;
    tick();
    chk_idle_outs("midrst");
    rst = 1'b0;
    tick();
    capture("rerun");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
